// File: rtl/box_bank.sv
// WIDTH x DEPTH register bank: registered write-first reads, per-entry valid bits,
// bulk clear, occupancy count and a sticky out-of-range error flag.
module box_bank #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              write_enable_i,
   input  logic [ADDR_W-1:0] write_address_i,
   input  logic [WIDTH-1:0]  write_data_i,
   input  logic              read_enable_i,
   input  logic [ADDR_W-1:0] read_address_i,
   input  logic              clear_i,
   output logic [WIDTH-1:0]  read_data_o,
   output logic              read_active_o,
   output logic              read_valid_o,
   output logic [ADDR_W:0]   occupied_o,
   output logic              error_o
);

   localparam logic [ADDR_W:0] DepthA = (ADDR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [WIDTH-1:0] read_data_q, read_data_d;
   logic             read_active_q, read_active_d;
   logic             read_valid_q, read_valid_d;
   logic [ADDR_W:0]  occupied_q, occupied_d;
   logic             error_q, error_d;
   logic             wr_in_range, rd_in_range;

   always_comb begin
      wr_in_range   = ({1'b0, write_address_i} < DepthA);
      rd_in_range   = ({1'b0, read_address_i} < DepthA);
      mem_d         = mem_q;
      valid_d       = clear_i ? '0 : valid_q;
      occupied_d    = '0;
      read_data_d   = read_data_q;
      read_active_d = read_enable_i;
      read_valid_d  = 1'b0;
      error_d       = error_q | (write_enable_i & ~wr_in_range) |
                      (read_enable_i & ~rd_in_range);

      // Clear is applied before the write so a same-cycle write survives.
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (write_enable_i && wr_in_range && write_address_i == ADDR_W'(i)) begin
            mem_d[i]   = write_data_i;
            valid_d[i] = 1'b1;
         end
      end

      for (int unsigned i = 0; i < DEPTH; i++) begin
         occupied_d = occupied_d + (ADDR_W + 1)'(valid_d[i]);
      end

      // Reads see the post-update array, giving write-first bypass.
      if (read_enable_i) begin
         read_data_d = '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rd_in_range && read_address_i == ADDR_W'(i) && valid_d[i]) begin
               read_data_d  = mem_d[i];
               read_valid_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         valid_q       <= '0;
         read_data_q   <= '0;
         read_active_q <= 1'b0;
         read_valid_q  <= 1'b0;
         occupied_q    <= '0;
         error_q       <= 1'b0;
      end else begin
         mem_q         <= mem_d;
         valid_q       <= valid_d;
         read_data_q   <= read_data_d;
         read_active_q <= read_active_d;
         read_valid_q  <= read_valid_d;
         occupied_q    <= occupied_d;
         error_q       <= error_d;
      end
   end

   assign read_data_o   = read_data_q;
   assign read_active_o = read_active_q;
   assign read_valid_o  = read_valid_q;
   assign occupied_o    = occupied_q;
   assign error_o       = error_q;

endmodule

// File: tb/tb_box_bank.sv
// Bench for box_bank: a DEPTH=4 and a DEPTH=3 instance share stimulus and are each
// compared against an array-based reference model.
module tb_box_bank;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       we = 1'b0;
   logic [1:0] wa = '0;
   logic [7:0] wd = '0;
   logic       re = 1'b0;
   logic [1:0] ra = '0;
   logic       clr = 1'b0;

   logic [7:0] rdata_w [2];
   logic       ract_w  [2];
   logic       rval_w  [2];
   logic [2:0] occ_w   [2];
   logic       err_w   [2];

   int checks = 0;
   int errors = 0;

   // Reference model state
   int         dep [2] = '{4, 3};
   logic [7:0] md  [2][4];
   logic       mv  [2][4];
   logic       merr [2];
   logic [7:0] e_rdata [2];
   logic       e_ract  [2];
   logic       e_rval  [2];
   int         e_occ   [2];

   always #5 clk = ~clk;

   box_bank #(.WIDTH(8), .DEPTH(4), .ADDR_W(2)) u_d4 (
      .clk_i(clk), .rst_ni(rst_n), .write_enable_i(we), .write_address_i(wa),
      .write_data_i(wd), .read_enable_i(re), .read_address_i(ra), .clear_i(clr),
      .read_data_o(rdata_w[0]), .read_active_o(ract_w[0]), .read_valid_o(rval_w[0]),
      .occupied_o(occ_w[0]), .error_o(err_w[0])
   );

   box_bank #(.WIDTH(8), .DEPTH(3), .ADDR_W(2)) u_d3 (
      .clk_i(clk), .rst_ni(rst_n), .write_enable_i(we), .write_address_i(wa),
      .write_data_i(wd), .read_enable_i(re), .read_address_i(ra), .clear_i(clr),
      .read_data_o(rdata_w[1]), .read_active_o(ract_w[1]), .read_valid_o(rval_w[1]),
      .occupied_o(occ_w[1]), .error_o(err_w[1])
   );

   task automatic check(input string tag, input int k, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d observed %0h expected %0h", tag, k, obs, exp);
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
               md[k][i] = '0;
               mv[k][i] = 1'b0;
            end
            merr[k] = 1'b0; e_rdata[k] = '0; e_ract[k] = 1'b0; e_rval[k] = 1'b0;
         end else begin
            if (clr) for (int i = 0; i < 4; i++) mv[k][i] = 1'b0;
            if (we) begin
               if (int'(wa) < dep[k]) begin
                  md[k][wa] = wd;
                  mv[k][wa] = 1'b1;
               end else merr[k] = 1'b1;
            end
            e_ract[k] = re;
            e_rval[k] = 1'b0;
            if (re) begin
               if (int'(ra) >= dep[k]) merr[k] = 1'b1;
               if (int'(ra) < dep[k] && mv[k][ra]) begin
                  e_rdata[k] = md[k][ra];
                  e_rval[k]  = 1'b1;
               end else e_rdata[k] = '0;
            end
         end
         e_occ[k] = 0;
         for (int i = 0; i < dep[k]; i++) e_occ[k] += int'(mv[k][i]);
      end
   endtask

   task automatic step(input logic i_rst_n, input logic i_we, input logic [1:0] i_wa,
                       input logic [7:0] i_wd, input logic i_re, input logic [1:0] i_ra,
                       input logic i_clr);
      rst_n = i_rst_n; we = i_we; wa = i_wa; wd = i_wd;
      re = i_re; ra = i_ra; clr = i_clr;
      @(posedge clk);
      model_edge();
      #1;
      for (int k = 0; k < 2; k++) begin
         check("read_data", k, 32'(rdata_w[k]), 32'(e_rdata[k]));
         check("read_active", k, 32'(ract_w[k]), 32'(e_ract[k]));
         check("read_valid", k, 32'(rval_w[k]), 32'(e_rval[k]));
         check("occupied", k, 32'(occ_w[k]), 32'(e_occ[k]));
         check("error", k, 32'(err_w[k]), 32'(merr[k]));
      end
   endtask

   initial begin
      // Reset, then empty reads
      step(0, 0, 0, 8'h00, 0, 0, 0);
      step(0, 0, 0, 8'h00, 0, 0, 0);
      for (int a = 0; a < 4; a++) step(1, 0, 0, 8'h00, 1, 2'(a), 0);
      // Clear out-of-range error the DEPTH=3 instance picked up on address 3
      step(0, 0, 0, 8'h00, 0, 0, 0);
      // Write/read back-to-back, then rewrite
      step(1, 1, 0, 8'hAA, 0, 0, 0);
      step(1, 1, 1, 8'h55, 0, 0, 0);
      step(1, 0, 0, 8'h00, 1, 0, 0);
      step(1, 0, 0, 8'h00, 1, 1, 0);
      step(1, 1, 0, 8'h11, 0, 0, 0);
      step(1, 0, 0, 8'h00, 0, 0, 0);
      // Bypass and simultaneity
      step(1, 1, 2, 8'h3C, 1, 2, 0);
      step(1, 1, 2, 8'h3D, 1, 3, 0);
      // Clear interaction
      for (int a = 0; a < 4; a++) step(1, 1, 2'(a), 8'(8'h20 + a), 0, 0, 0);
      step(1, 1, 1, 8'h7E, 1, 1, 1);
      step(1, 0, 0, 8'h00, 1, 0, 0);
      // Out of range (address 3 on the DEPTH=3 instance)
      step(1, 1, 3, 8'hFF, 0, 0, 0);
      step(1, 0, 0, 8'h00, 1, 3, 0);
      step(1, 0, 0, 8'h00, 0, 0, 0);
      step(0, 0, 0, 8'h00, 0, 0, 0);
      // Reset mid-operation with a read outstanding
      step(1, 1, 0, 8'h42, 0, 0, 0);
      step(1, 1, 1, 8'h43, 1, 0, 0);
      step(0, 0, 0, 8'h00, 1, 1, 0);
      for (int a = 0; a < 4; a++) step(1, 0, 0, 8'h00, 1, 2'(a), 0);
      // Randomised traffic
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 29) != 0), 1'($urandom), 2'($urandom), 8'($urandom),
              1'($urandom), 2'($urandom), ($urandom_range(0, 7) == 0));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
